// File: rtl/scan_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_window_sequencer
//  Purpose  : Sequences a scan-line window buffer (winRow rows x imCol
//             registers with window registers at the row tails). Accepts a
//             raster pixel stream with valid/ready and drives the buffer's
//             (bufMode, bufEnable) pair:
//                HOLD   = (1,0) : every register holds
//                SHIFT  = (0,1) : whole chain shifts one pixel
//                ROTATE = (1,1) : window registers loop around, rest hold
//             Tracks the image row/column and flags when the window lies
//             fully inside the image. Optionally serialises each valid
//             window with downstream backpressure.
//  Ports    : clock, reset (async, active-low)
//             start, serialEn            - frame start / serial mode select
//             pixValid, pixReady         - upstream pixel handshake
//             bufEnable, bufMode         - buffer control pair
//             winValid, winRowIdx/ColIdx - parallel window strobe + position
//             serialValid/Ready/Last     - serial window readout handshake
//             busy, frameDone            - status
//  Revision : 1.0 - initial release
// ============================================================================
module scan_window_sequencer #(
   parameter int winCol = 42,
   parameter int winRow = 42,
   parameter int imCol  = 60,
   parameter int imRow  = 60
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       serialEn,
   input  logic                       pixValid,
   output logic                       pixReady,
   output logic                       bufEnable,
   output logic                       bufMode,
   output logic                       winValid,
   output logic [$clog2(imRow)-1:0]   winRowIdx,
   output logic [$clog2(imCol)-1:0]   winColIdx,
   output logic                       serialValid,
   input  logic                       serialReady,
   output logic                       serialLast,
   output logic                       busy,
   output logic                       frameDone
);

   localparam int ROW_W  = $clog2(imRow);
   localparam int COL_W  = $clog2(imCol);
   localparam int BEAT_W = $clog2(winRow * winCol + 1);

   localparam logic [ROW_W-1:0]  c_ROW_LAST  = ROW_W'(imRow - 1);
   localparam logic [COL_W-1:0]  c_COL_LAST  = COL_W'(imCol - 1);
   localparam logic [ROW_W-1:0]  c_ROW_MIN   = ROW_W'(winRow - 1);
   localparam logic [COL_W-1:0]  c_COL_MIN   = COL_W'(winCol - 1);
   localparam logic [BEAT_W-1:0] c_BEAT_LAST = BEAT_W'(winRow * winCol - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      SERIAL = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [ROW_W-1:0]    r_row;
   logic [COL_W-1:0]    r_col;
   logic [BEAT_W-1:0]   r_beat;
   logic                r_serialEn;
   logic                r_lastSeen;
   logic                r_winValid;
   logic [ROW_W-1:0]    r_winRowIdx;
   logic [COL_W-1:0]    r_winColIdx;
   logic                r_frameDone;

   logic                w_accept;
   logic                w_inBounds;
   logic                w_lastPix;
   logic                w_beatLast;

   assign w_accept   = (r_state == STREAM) && pixValid;
   // A window straddling a row wrap has col < winCol-1, so the column test
   // alone excludes it.
   assign w_inBounds = (r_row >= c_ROW_MIN) && (r_col >= c_COL_MIN);
   assign w_lastPix  = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
   assign w_beatLast = (r_beat == c_BEAT_LAST);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and buffer control. Outputs in STREAM follow pixValid
   // combinationally so the buffer shifts on the same edge that accepts.
   // ------------------------------------------------------------------------
   always_comb begin
      w_nextState = r_state;
      pixReady    = 1'b0;
      bufMode     = 1'b1;
      bufEnable   = 1'b0;
      serialValid = 1'b0;
      serialLast  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = STREAM;
            end
         end
         STREAM: begin
            pixReady = 1'b1;
            if (pixValid) begin
               bufMode   = 1'b0;
               bufEnable = 1'b1;
               // The final pixel's window is always in bounds.
               if (w_lastPix) begin
                  w_nextState = r_serialEn ? SERIAL : DONE;
               end else if (w_inBounds && r_serialEn) begin
                  w_nextState = SERIAL;
               end
            end
         end
         SERIAL: begin
            serialValid = 1'b1;
            serialLast  = w_beatLast;
            if (serialReady) begin
               bufEnable = 1'b1;
               if (w_beatLast) begin
                  w_nextState = r_lastSeen ? DONE : STREAM;
               end
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Position, beat counter and registered strobes
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_row       <= '0;
         r_col       <= '0;
         r_beat      <= '0;
         r_serialEn  <= 1'b0;
         r_lastSeen  <= 1'b0;
         r_winValid  <= 1'b0;
         r_winRowIdx <= '0;
         r_winColIdx <= '0;
         r_frameDone <= 1'b0;
      end else begin
         r_winValid  <= w_accept && w_inBounds;
         // frameDone trails the DONE state so it lands one cycle after the
         // final window strobe.
         r_frameDone <= (r_state == DONE);

         if ((r_state == IDLE) && start) begin
            r_serialEn <= serialEn;
            r_row      <= '0;
            r_col      <= '0;
            r_lastSeen <= 1'b0;
         end

         if (w_accept) begin
            r_winRowIdx <= r_row;
            r_winColIdx <= r_col;
            if (r_col == c_COL_LAST) begin
               r_col <= '0;
               r_row <= w_lastPix ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
            if (w_lastPix) begin
               r_lastSeen <= 1'b1;
            end
            if (w_inBounds) begin
               r_beat <= '0;
            end
         end

         if ((r_state == SERIAL) && serialReady) begin
            r_beat <= r_beat + 1'b1;
         end
      end
   end

   assign winValid  = r_winValid;
   assign winRowIdx = r_winRowIdx;
   assign winColIdx = r_winColIdx;
   assign frameDone = r_frameDone;
   assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_scan_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_window_sequencer
//  Purpose  : Randomised self-checking bench for scan_window_sequencer with a
//             count-based reference model of the frame/window/serial rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scan_window_sequencer;

   localparam int WC    = 3;
   localparam int WR    = 3;
   localparam int IMC   = 5;
   localparam int IMR   = 4;
   localparam int TOTAL = IMC * IMR;
   localparam int BEATS = WR * WC;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic serialEn = 1'b0;
   logic pixValid = 1'b0;
   logic serialReady = 1'b0;
   logic pixReady, bufEnable, bufMode, winValid, serialValid, serialLast;
   logic busy, frameDone;
   logic [$clog2(IMR)-1:0] winRowIdx;
   logic [$clog2(IMC)-1:0] winColIdx;

   scan_window_sequencer #(
      .winCol(WC), .winRow(WR), .imCol(IMC), .imRow(IMR)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .serialEn(serialEn),
      .pixValid(pixValid), .pixReady(pixReady), .bufEnable(bufEnable),
      .bufMode(bufMode), .winValid(winValid), .winRowIdx(winRowIdx),
      .winColIdx(winColIdx), .serialValid(serialValid),
      .serialReady(serialReady), .serialLast(serialLast), .busy(busy),
      .frameDone(frameDone)
   );

   always #5 clock = ~clock;

   int nChecks = 0;
   int nPass   = 0;

   task automatic checkVal(input string tag, input int got, input int exp);
      nChecks++;
      if (got === exp) begin
         nPass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (counts, not states) -----------------
   bit mBusy, mDone, mSerEn, mWin, mFd;
   int mAcc, mSerLeft, mWr, mWc;
   // per-frame observations
   int winCnt, doneCnt, rotCnt, firstR, firstC, lastR, lastC;

   task automatic modelReset();
      mBusy = 0; mDone = 0; mSerEn = 0; mWin = 0; mFd = 0;
      mAcc = 0; mSerLeft = 0; mWr = 0; mWc = 0;
   endtask

   task automatic monitorStep();
      bit expPr, expSv, expEn, expMode, nWin, nFd;
      int r, c;
      if (!reset) begin
         checkVal("rst_bufMode", bufMode, 1);
         checkVal("rst_bufEnable", bufEnable, 0);
         checkVal("rst_pixReady", pixReady, 0);
         checkVal("rst_busy", busy, 0);
         checkVal("rst_winValid", winValid, 0);
         checkVal("rst_serialValid", serialValid, 0);
         checkVal("rst_serialLast", serialLast, 0);
         checkVal("rst_frameDone", frameDone, 0);
         checkVal("rst_winRowIdx", winRowIdx, 0);
         checkVal("rst_winColIdx", winColIdx, 0);
         modelReset();
         return;
      end
      expPr = mBusy && !mDone && (mSerLeft == 0);
      expSv = (mSerLeft > 0);
      if (expPr) begin
         expMode = !pixValid; expEn = pixValid;
      end else if (expSv) begin
         expMode = 1; expEn = serialReady;
      end else begin
         expMode = 1; expEn = 0;
      end
      checkVal("pixReady", pixReady, expPr);
      checkVal("bufMode", bufMode, expMode);
      checkVal("bufEnable", bufEnable, expEn);
      checkVal("serialValid", serialValid, expSv);
      checkVal("serialLast", serialLast, mSerLeft == 1);
      checkVal("busy", busy, mBusy);
      checkVal("winValid", winValid, mWin);
      checkVal("frameDone", frameDone, mFd);
      if (winValid) begin
         winCnt++;
         checkVal("winRowIdx", winRowIdx, mWr);
         checkVal("winColIdx", winColIdx, mWc);
         if (winCnt == 1) begin firstR = winRowIdx; firstC = winColIdx; end
         lastR = winRowIdx; lastC = winColIdx;
      end
      if (frameDone) doneCnt++;

      // advance the model across the coming clock edge
      nWin = 0; nFd = 0;
      if (mDone) begin
         mDone = 0; mBusy = 0; nFd = 1;
      end else if (!mBusy) begin
         if (start) begin
            mBusy = 1; mSerEn = serialEn; mAcc = 0;
         end
      end else if (mSerLeft > 0) begin
         if (serialReady) begin
            rotCnt++;
            mSerLeft--;
            if (mSerLeft == 0 && mAcc == TOTAL) mDone = 1;
         end
      end else if (pixValid) begin
         r = mAcc / IMC;
         c = mAcc % IMC;
         mAcc++;
         if (r >= WR - 1 && c >= WC - 1) begin
            nWin = 1; mWr = r; mWc = c;
            if (mSerEn) mSerLeft = BEATS;
         end
         if (mAcc == TOTAL && mSerLeft == 0) mDone = 1;
      end
      mWin = nWin;
      mFd  = nFd;
   endtask

   initial begin
      modelReset();
      forever begin
         @(negedge clock);
         monitorStep();
      end
   end

   // ---------------- stimulus ----------------------------------------------
   // readyMode: 0 = always ready, 1 = toggle each cycle, 2 = random
   task automatic runFrame(input bit sEn, input int validPct, input int readyMode,
                           input bit chaos);
      bit done;
      winCnt = 0; doneCnt = 0; rotCnt = 0;
      firstR = -1; firstC = -1; lastR = -1; lastC = -1;
      @(posedge clock); #1;
      start = 1; serialEn = sEn; pixValid = 0; serialReady = 1;
      @(posedge clock); #1;
      start = 0;
      done = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         pixValid = ($urandom_range(99) < validPct);
         case (readyMode)
            0:       serialReady = 1;
            1:       serialReady = ~serialReady;
            default: serialReady = $urandom_range(1);
         endcase
         if (chaos) begin
            serialEn = $urandom_range(1);
            start    = (mSerLeft > 0) && ($urandom_range(3) == 0);
         end
         @(posedge clock); #1;
         if (doneCnt > 0) begin done = 1; break; end
      end
      start = 0; pixValid = 0; serialEn = 0;
      checkVal("frame_timeout", done, 1);
      checkVal("winCount", winCnt, 6);
      checkVal("doneCount", doneCnt, 1);
      checkVal("firstWinRow", firstR, 2);
      checkVal("firstWinCol", firstC, 2);
      checkVal("lastWinRow", lastR, 3);
      checkVal("lastWinCol", lastC, 4);
      checkVal("rotateCount", rotCnt, sEn ? 6 * BEATS : 0);
   endtask

   initial begin
      bit reached;
      reset = 0;
      repeat (3) @(posedge clock);
      #1 reset = 1;

      // reset in the middle of a streaming frame
      @(posedge clock); #1;
      start = 1; serialEn = 0;
      @(posedge clock); #1;
      start = 0;
      reached = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         pixValid = 1;
         @(posedge clock); #1;
         if (mAcc >= 7) begin reached = 1; break; end
      end
      checkVal("rst_seq_reach7", reached, 1);
      pixValid = 0;
      reset = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1;

      runFrame(0, 100, 0, 0);   // back-to-back parallel
      runFrame(0, 50, 0, 0);    // random gaps
      runFrame(1, 100, 0, 0);   // serial, always ready
      runFrame(1, 100, 1, 0);   // serial, ready toggling
      runFrame(1, 60, 2, 1);    // serial, random, stray starts / serialEn flips

      // pixValid offered while idle must never shift the buffer
      pixValid = 1;
      repeat (8) @(posedge clock);
      #1 pixValid = 0;
      @(negedge clock);
      checkVal("idle_busy", busy, 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/scan_window_sequencer.md
Name: scan_window_sequencer

Overview:
- Controller that sequences the scan-line window buffer (chain of winRow rows × imCol registers, window registers at the row tails, 2:1 mode mux feeding the row-0 window head).
- Accepts a raster pixel stream with valid/ready and drives the buffer's enable/mode pair so the buffer shifts once per accepted pixel.
- Tracks image row/column, flags when the parallel window lies fully inside the image, and optionally runs the serial loop-around readout of each valid window with downstream backpressure.

Parameters:
- winCol, 42, window width in pixels; 1 ≤ winCol ≤ imCol.
- winRow, 42, window height in pixels; 1 ≤ winRow ≤ imRow.
- imCol, 60, image width in pixels.
- imRow, 60, image height in pixels.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
- serialEn  input  1  sampled at start; 1 = serialise every valid window.
- pixValid  input  1  upstream pixel present on the buffer's dataIn.
- pixReady  output  1  pixel accepted this cycle when pixValid & pixReady.
- bufEnable  output  1  drives buffer enable.
- bufMode  output  1  drives buffer mode.
- winValid  output  1  one-cycle pulse: parallel window output is valid.
- winRowIdx  output  $clog2(imRow)  image row of the window's bottom-right pixel; held until the next accept.
- winColIdx  output  $clog2(imCol)  image column of the window's bottom-right pixel; held until the next accept.
- serialValid  output  1  buffer serialOut carries a window element.
- serialReady  input  1  downstream accepts the serial element.
- serialLast  output  1  marks the final serial element (beat winRow*winCol-1).
- busy  output  1  high in any state other than IDLE.
- frameDone  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Buffer control encoding (bufMode, bufEnable); non-window buffer registers are enabled by ~mode:
  - HOLD = (1,0): all registers hold.
  - SHIFT = (0,1): whole chain shifts one pixel.
  - ROTATE = (1,1): window registers loop around; others hold.
  - (0,0) is never driven.
- Reset (asynchronous, any time, including mid-frame or mid-serial):
  - State = IDLE, all counters = 0.
  - bufMode=1, bufEnable=0, pixReady=0.
  - winValid, serialValid, serialLast, busy, frameDone all 0.
  - winRowIdx=0, winColIdx=0.
- States: IDLE, STREAM, SERIAL, DONE.
- IDLE:
  - Outputs HOLD.
  - On start: latch serialEn, clear row/col, go to STREAM.
- STREAM:
  - pixReady=1.
  - Outputs are combinational: pixValid=1 gives SHIFT in that same cycle; otherwise HOLD.
  - On each accept at (row,col):
    - winRowIdx/winColIdx ← (row,col).
    - col increments and wraps to 0 at imCol-1; row increments on wrap.
    - The window is in-bounds iff row ≥ winRow-1 and col ≥ winCol-1. Windows straddling a row wrap never flag.
  - In-bounds accept with serialEn=0: winValid=1 in the following cycle only; stay in STREAM.
  - In-bounds accept with serialEn=1: winValid=1 in the following cycle; go to SERIAL with beat=0.
  - Accept of the last pixel (imRow-1, imCol-1): go to DONE, or to SERIAL first if serialEn; that window is always in-bounds.
- SERIAL:
  - pixReady=0.
  - serialValid=1; serialLast=1 when beat = winRow*winCol-1.
  - serialReady=1: ROTATE, beat increments.
  - serialReady=0: HOLD, beat unchanged, serialValid stays 1.
  - After the last beat is accepted: return to STREAM, or to DONE if the frame's last pixel has been consumed.
- DONE: frameDone=1 for exactly one cycle, HOLD, then IDLE.
- Latency and throughput:
  - Window reflects a pixel one cycle after its accepting edge.
  - Peak rate is 1 pixel/cycle in parallel mode.
  - In serial mode, each valid window stalls input for at least winRow*winCol cycles.
- Boundary conditions:
  - start while busy: ignored.
  - pixValid in IDLE, SERIAL or DONE: not accepted.
  - serialEn changes mid-frame: no effect.
  - winCol=imCol: every row position col=imCol-1 qualifies once row ≥ winRow-1.
- Counter widths: $clog2 of each bound. Beat counter is $clog2(winRow*winCol+1) wide.

Test Plan (winCol=3, winRow=3, imCol=5, imRow=4 unless stated):
- Reset mid-STREAM after 7 accepted pixels, then release:
  - Expect HOLD (bufMode=1, bufEnable=0), pixReady=0, busy=0.
  - A new start restarts at (0,0).
- serialEn=0, pixValid held high for 20 pixels:
  - winValid pulses exactly 6 times.
  - First pulse follows accept #13 with idx (2,2); last pulse has idx (3,4).
  - frameDone follows 1 cycle after the final winValid.
- Random pixValid gaps (50% duty):
  - bufEnable=1 only in cycles where pixValid & pixReady.
  - Same 6 windows and indices as the back-to-back case.
- serialEn=1, serialReady=1:
  - After accept #13, SERIAL lasts exactly 9 cycles of ROTATE; serialLast on the 9th.
  - pixReady=0 throughout; STREAM resumes next.
- serialEn=1, serialReady toggling 1,0,1,0:
  - 9 ROTATE cycles spread over 18 cycles; beats not lost.
  - serialValid stays high in stalled cycles.
- start pulse during SERIAL and pixValid asserted in IDLE:
  - No state change.
  - No bufEnable.
